// File: rtl/regop_scheduler.sv
// regop_scheduler: two-requester round-robin command scheduler driving a
// 4-bit working register with load / complement / shift-right / shift-left
// commands, each repeated cnt+1 times (load always runs once).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitrate, accept at most one command, hold q
// EXEC  | apply one step per cycle, leave after the final step with done
module regop_scheduler #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [3:0]       req0_data,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [3:0]       req1_data,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic [3:0]       q,
    output logic             busy,
    output logic             done,
    output logic             done_id
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_COMP = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    state_t           state_q, state_d;
    logic [3:0]       q_q, q_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       data_q, data_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             last_id_q, last_id_d;

    logic             grant_vld;
    logic             grant_id;
    logic [1:0]       sel_op;
    logic [3:0]       sel_data;
    logic [CNT_W-1:0] sel_cnt;

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_id_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id && reset;
    assign req1_ready = grant_vld &&  grant_id && reset;

    assign sel_op   = grant_id ? req1_op   : req0_op;
    assign sel_data = grant_id ? req1_data : req0_data;
    assign sel_cnt  = grant_id ? req1_cnt  : req0_cnt;

    // Next-state: accept in IDLE, one datapath step per EXEC cycle.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        op_d      = op_q;
        data_d    = data_q;
        id_d      = id_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        last_id_d = last_id_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    op_d    = sel_op;
                    data_d  = sel_data;
                    id_d    = grant_id;
                    rem_d   = (sel_op == OP_LOAD) ? '0 : sel_cnt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_LOAD: q_d = data_q;
                    OP_COMP: q_d = ~q_q;
                    OP_SHR:  q_d = {1'b0, q_q[3:1]};
                    OP_SHL:  q_d = {q_q[2:0], 1'b0};
                    default: q_d = q_q;
                endcase
                if (rem_q == '0) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    last_id_d = id_q;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            q_q       <= 4'b0000;
            op_q      <= OP_LOAD;
            data_q    <= 4'b0000;
            id_q      <= 1'b0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            last_id_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            op_q      <= op_d;
            data_q    <= data_d;
            id_q      <= id_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            last_id_q <= last_id_d;
        end
    end

    assign q       = q_q;
    assign busy    = (state_q == EXEC);
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule
